// File: rtl/barcode_id_decoder.sv
// barcode_id_decoder
//   Turns the serial barcode strip seen by the optical sensor into an 8-bit
//   station ID. Each frame is one start bit and then 8 data bits, MSB first.
//   Every bit begins with a falling edge. The low time of the start bit (T)
//   sets the sample point for the data bits: each data bit is sampled T cycles
//   after its own falling edge.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   BC         : raw barcode input, asynchronous, idles high
//   clr_ID_vld : consumer acknowledge, clears ID_vld
//   ID         : last valid decoded station ID
//   ID_vld     : ID holds a new valid ID that has not been acknowledged
//
// State        | meaning
// -------------+------------------------------------------------------------
// IDLE         | waiting for the falling edge that opens a start bit
// START_LOW    | measuring the start-bit low time T
// WAIT_FALL    | waiting for the falling edge of the next data bit
// SAMPLE_WAIT  | counting up to T after a data-bit edge, then sampling
module barcode_id_decoder #(
    parameter int TIMER_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        START_LOW   = 2'd1,
        WAIT_FALL   = 2'd2,
        SAMPLE_WAIT = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] CNT_MAX = '1;
    localparam logic [TIMER_W-1:0] CNT_ONE = TIMER_W'(1);

    state_t               state_q, state_d;
    logic                 bc_meta_q, bc_s_q, bc_prev_q;
    logic [TIMER_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0]   t_q, t_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 done_q, done_d;
    logic [7:0]           id_q, id_d;
    logic                 id_vld_q, id_vld_d;
    logic                 fall;

    assign fall   = bc_prev_q & ~bc_s_q;
    assign ID     = id_q;
    assign ID_vld = id_vld_q;

    // Synchronisers reset to the idle-high level so release of reset never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_meta_q <= 1'b1;
            bc_s_q    <= 1'b1;
            bc_prev_q <= 1'b1;
        end else begin
            bc_meta_q <= BC;
            bc_s_q    <= bc_meta_q;
            bc_prev_q <= bc_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            t_q       <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            done_q    <= 1'b0;
            id_q      <= 8'h00;
            id_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
        end
    end

    // cnt_q doubles as the start-bit timer, the inter-edge gap timer and the
    // sample timer; only one of those is ever running at a time.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d     = CNT_ONE;
                    bit_cnt_d = 3'd0;
                    state_d   = START_LOW;
                end
            end
            START_LOW: begin
                if (bc_s_q) begin
                    t_d     = cnt_q;
                    cnt_d   = '0;
                    state_d = WAIT_FALL;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    cnt_d   = CNT_ONE;
                    state_d = SAMPLE_WAIT;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SAMPLE_WAIT: begin
                // Edges inside the bit are ignored; only the level at cnt==T counts.
                if (cnt_q == t_q) begin
                    shift_d   = {shift_q[6:0], bc_s_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_FALL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed frame with a valid prefix beats a simultaneous acknowledge.
    always_comb begin
        id_d     = id_q;
        id_vld_d = id_vld_q;
        if (done_q && (shift_q[7:6] == 2'b00)) begin
            id_d     = shift_q;
            id_vld_d = 1'b1;
        end else if (clr_ID_vld) begin
            id_vld_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_barcode_id_decoder.sv
module tb_barcode_id_decoder;

    logic       clk;
    logic       rst_n;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       vld_prev = 1'b0;
    logic [7:0] id_prev  = 8'h00;

    barcode_id_decoder #(.TIMER_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        BC = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Start bit low t, high t; data bits of period 2t, a 1 low t/2, a 0 low 3t/2.
    // Cycle counts after the last bit's falling edge: sample lands on posedge t+3,
    // ID_vld updates on posedge t+4.
    task automatic send_bits(input logic [7:0] data, input int t, input int nbits,
                             input bit chk_lat, input bit clr_end);
        logic bv;
        int   low;
        BC = 1'b0;
        repeat (t) @(negedge clk);
        BC = 1'b1;
        repeat (t) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            bv  = data[7-b];
            low = bv ? t / 2 : (3 * t) / 2;
            for (int c = 0; c < 2 * t; c++) begin
                BC = (c < low) ? 1'b0 : 1'b1;
                @(negedge clk);
                if (b == 7 && chk_lat && c + 1 == t + 3) chk("lat_before", ID_vld, 1'b0);
                if (b == 7 && chk_lat && c + 1 == t + 4) chk("lat_rise", ID_vld, 1'b1);
                if (b == 7 && clr_end && c + 1 == t + 3) clr_ID_vld = 1'b1;
                if (b == 7 && clr_end && c + 1 == t + 4) begin
                    clr_ID_vld = 1'b0;
                    chk("simul_vld", ID_vld, 1'b1);
                    chk("simul_id", ID, 8'h02);
                end
            end
        end
        BC = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
    endtask

    // Scoreboard: every new ID publication must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ID_vld && (!vld_prev || ID != id_prev)) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("sb_id", ID, exp_q.pop_front());
            end
            vld_prev <= ID_vld;
            id_prev  <= ID;
        end else begin
            vld_prev <= 1'b0;
            id_prev  <= 8'h00;
        end
    end

    initial begin
        BC         = 1'b1;
        clr_ID_vld = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_id", ID, 8'h00);
        chk("rst_vld", ID_vld, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // nominal frame
        exp_q.push_back(8'h25);
        send_bits(8'h25, 100, 8, 1'b1, 1'b0);
        idle(30);
        chk("nom_hold_vld", ID_vld, 1'b1);
        chk("nom_id", ID, 8'h25);
        pulse_clr();
        chk("nom_clr_vld", ID_vld, 1'b0);
        chk("nom_clr_id", ID, 8'h25);
        pulse_clr();
        chk("clr_idle_vld", ID_vld, 1'b0);

        // invalid prefix
        send_bits(8'hC5, 100, 8, 1'b0, 1'b0);
        idle(30);
        chk("inv_vld", ID_vld, 1'b0);
        chk("inv_id", ID, 8'h25);

        // start-bit timeout, then a good frame
        BC = 1'b0;
        repeat (300) @(negedge clk);
        idle(30);
        chk("tmo_vld", ID_vld, 1'b0);
        chk("tmo_id", ID, 8'h25);
        exp_q.push_back(8'h12);
        send_bits(8'h12, 40, 8, 1'b0, 1'b0);
        idle(20);
        chk("tmo_next_vld", ID_vld, 1'b1);
        chk("tmo_next_id", ID, 8'h12);
        pulse_clr();

        // mid-frame gap abort
        send_bits(8'h00, 40, 4, 1'b0, 1'b0);
        idle(300);
        chk("gap_vld", ID_vld, 1'b0);
        exp_q.push_back(8'h3F);
        send_bits(8'h3F, 40, 8, 1'b0, 1'b0);
        idle(20);
        chk("gap_next_vld", ID_vld, 1'b1);
        chk("gap_next_id", ID, 8'h3F);

        // latest wins, then set and clear together
        exp_q.push_back(8'h01);
        send_bits(8'h01, 40, 8, 1'b0, 1'b0);
        idle(20);
        chk("ovr_id", ID, 8'h01);
        chk("ovr_vld", ID_vld, 1'b1);
        exp_q.push_back(8'h02);
        send_bits(8'h02, 40, 8, 1'b0, 1'b1);
        idle(20);
        chk("simul_hold_vld", ID_vld, 1'b1);
        chk("simul_hold_id", ID, 8'h02);

        // reset during bit 3
        send_bits(8'h0A, 40, 3, 1'b0, 1'b0);
        BC = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_id", ID, 8'h00);
        chk("mrst_vld", ID_vld, 1'b0);
        repeat (3) @(negedge clk);
        BC    = 1'b1;
        rst_n = 1'b1;
        idle(20);
        chk("mrst_after_vld", ID_vld, 1'b0);
        exp_q.push_back(8'h0A);
        send_bits(8'h0A, 40, 8, 1'b0, 1'b0);
        idle(20);
        chk("mrst_next_id", ID, 8'h0A);
        chk("mrst_next_vld", ID_vld, 1'b1);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/barcode_id_decoder.md
Name: barcode_id_decoder

Overview:
- Decodes the serial barcode strip signal seen by the optical sensor into an 8-bit station ID.
- Presents the ID to command and control through the ID / ID_vld / clr_ID_vld handshake.
- ID_vld stays high until the consumer pulses clr_ID_vld.
- Self-timing: the width of the start bit sets the sample point for every data bit in that frame.

Parameters:
- TIMER_W, 22, width of the duration/sample counter; sets the maximum start-bit length and inter-edge gap, 2^TIMER_W-1 cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- BC  input  1  raw barcode serial input, asynchronous; idles high
- clr_ID_vld  input  1  consumer acknowledge; clears ID_vld
- ID  output  8  last valid decoded station ID
- ID_vld  output  1  ID holds a new valid ID not yet acknowledged

Behaviour:
- Reset values: ID=8'h00, ID_vld=0, state=IDLE, counters=0, sync flops=1 (BC idle level).
- Synchronisation:
  - BC passes through two flops to give BC_s.
  - A third flop holds BC_s_prev.
  - fall = BC_s_prev & ~BC_s.
  - All decoding uses BC_s only.
- Frame format: one start bit followed by 8 data bits, MSB first. Every bit begins with a falling edge.
  - Start bit: low for T cycles, then high.
  - Data bit: sampled T cycles after its falling edge. BC_s high at the sample gives 1; low gives 0.
- States: IDLE, START_LOW, WAIT_FALL, SAMPLE_WAIT.
- IDLE:
  - On fall: cnt=1, bit_cnt=0, go to START_LOW.
- START_LOW:
  - While BC_s=0, cnt increments every cycle.
  - When BC_s=1: T=cnt (latched), go to WAIT_FALL.
  - If cnt reaches all-ones while still low: abort to IDLE.
- WAIT_FALL:
  - gap counter increments each cycle.
  - On fall: cnt=1, go to SAMPLE_WAIT.
  - If the gap counter reaches all-ones: abort to IDLE and discard the partial frame.
- SAMPLE_WAIT:
  - cnt increments each cycle.
  - In the cycle cnt==T: shift_reg = {shift_reg[6:0], BC_s}, bit_cnt++.
  - If bit_cnt was 7, the frame is complete; go to IDLE. Otherwise go to WAIT_FALL.
- Sampling at cnt==T is independent of BC_s edges inside the bit. An early rising edge (a 1 bit) is ignored until the sample.
- Frame completion, the cycle after the 8th sample:
  - If shift_reg[7:6]==2'b00: ID<=shift_reg and ID_vld<=1.
  - Otherwise the frame is discarded; ID and ID_vld are unchanged.
- ID changes only at a valid completion. It is stable while ID_vld=1 unless a newer valid frame completes, which overwrites it (latest wins).
- ID_vld:
  - Cleared on clr_ID_vld.
  - If set and clr_ID_vld occur in the same cycle, set wins and ID_vld stays 1 with the new ID.
  - clr_ID_vld while ID_vld=0 has no effect.
- Decoding continues regardless of ID_vld. There is no backpressure on the barcode.
- Abort leaves ID and ID_vld untouched. The next fall in IDLE starts a fresh frame.
- Reset asserted mid-frame:
  - Immediately returns all state to its reset values.
  - After release, a frame already in progress decodes only if its start bit begins after reset.
- Latency: ID_vld rises 1 cycle after the cycle in which bit 0 is sampled.

Test Plan:
- Nominal frame:
  - Stimulus: start low 100 cycles; bit period 200 cycles; 1-bits low 50 cycles, 0-bits low 150 cycles; data 8'h25.
  - Response: ID=8'h25 and ID_vld=1 exactly 1 cycle after the 8th sample; ID_vld stays 1 until clr_ID_vld, then 0 the next cycle.
- Invalid frame:
  - Stimulus: after the nominal frame and a clear, send 8'hC5.
  - Response: ID_vld stays 0 and ID stays 8'h25.
- Timeout (TIMER_W=8):
  - Stimulus: hold BC low 300 cycles, release; then send a valid 8'h12 frame with T=40.
  - Response: no ID_vld from the long pulse; the subsequent frame gives ID=8'h12, ID_vld=1.
- Mid-frame gap:
  - Stimulus: stop the frame after 4 bits and hold BC high for more than 2^TIMER_W cycles; then send 8'h3F.
  - Response: the partial frame is discarded; ID=8'h3F.
- Simultaneous set/clear:
  - Stimulus: ID_vld=1 with 8'h01; pulse clr_ID_vld in the exact cycle a frame carrying 8'h02 completes.
  - Response: ID_vld=1, ID=8'h02.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during bit 3 of a frame; release; send 8'h0A.
  - Response: ID=0 and ID_vld=0 during reset; afterwards ID=8'h0A with ID_vld=1.
